// File: rtl/trace_pkg.sv
// Shared record type, widths and defaults for the o_reg trace capture block.
package trace_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_TS_W   = 16;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DROP_W     = 8;

    // Channel index width; a single channel still gets one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W = ch_width(DEF_NUM_CH);

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_TS_W-1:0]   ts;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO of trace records.
// When empty, head keeps showing the most recently popped record.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter type         rec_t = trace_rec_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  rec_t                   push_rec,
    input  logic                   pop,
    output rec_t                   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    rec_t          mem_q [DEPTH];
    rec_t          last_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        // A pop frees the slot on the same edge, so a full FIFO may still accept.
        do_push = push && (!full || do_pop);
        head    = empty ? last_q : mem_q[rptr_q];
        level   = count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_rec;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                last_q <= mem_q[rptr_q];
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/oreg_trace_capture.sv
// Timestamped change capture for the o_reg bus: detect, pend, round-robin push into a FIFO.
// Define TRACE_FILTER_EN to add the chan_mask input for per-channel filtering.
module oreg_trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TS_W   = DEF_TS_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_CH*DATA_W-1:0]      o_reg_bus,
`ifdef TRACE_FILTER_EN
    input  logic [NUM_CH-1:0]             chan_mask,
`endif
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [ch_width(NUM_CH)-1:0]   rd_ch,
    output logic [DATA_W-1:0]             rd_data,
    output logic [TS_W-1:0]               rd_ts,
    output logic [$clog2(DEPTH):0]        level,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int unsigned CH_BITS = ch_width(NUM_CH);

    typedef struct packed {
        logic [CH_BITS-1:0] ch;
        logic [DATA_W-1:0]  data;
        logic [TS_W-1:0]    ts;
    } rec_t;

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [DATA_W-1:0]  prev_q [NUM_CH];
    logic [DATA_W-1:0]  cur [NUM_CH];
    logic [NUM_CH-1:0]  pending_q, pending_d, detect, live;
    logic [DATA_W-1:0]  pend_val_q [NUM_CH];
    logic [DATA_W-1:0]  pend_val_d [NUM_CH];
    logic [TS_W-1:0]    pend_ts_q [NUM_CH];
    logic [TS_W-1:0]    pend_ts_d [NUM_CH];
    logic [CH_BITS-1:0] rr_q, rr_d, gnt_ch;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               gnt_valid, push, pop, full, empty;
    rec_t               push_rec, head;

`ifdef TRACE_FILTER_EN
    always_comb live = chan_mask;
`else
    always_comb live = '1;
`endif

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cur[c]    = o_reg_bus[c*DATA_W +: DATA_W];
            detect[c] = enable && live[c] && (cur[c] != prev_q[c]);
        end
    end

    // Round-robin search starting at rr_q.
    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(rr_q) + i) % NUM_CH;
            if (!gnt_valid && pending_q[idx] && live[idx]) begin
                gnt_valid = 1'b1;
                gnt_ch    = CH_BITS'(idx);
            end
        end
        pop      = rd_valid && rd_ready;
        push     = gnt_valid && (!full || pop);
        push_rec = '{ch: gnt_ch, data: pend_val_q[gnt_ch], ts: pend_ts_q[gnt_ch]};
    end

    always_comb begin
        ts_d       = enable ? ts_q + 1'b1 : ts_q;
        pending_d  = pending_q;
        pend_val_d = pend_val_q;
        pend_ts_d  = pend_ts_q;
        drop_d     = drop_q;
        rr_d       = rr_q;
        if (push) begin
            pending_d[gnt_ch] = 1'b0;
            rr_d = (gnt_ch == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (detect[c]) begin
                // Only an unsent pending value is lost; one leaving this edge is not.
                if (pending_q[c] && !(push && gnt_ch == CH_BITS'(c)) && drop_d != '1) begin
                    drop_d = drop_d + 1'b1;
                end
                pending_d[c]  = 1'b1;
                pend_val_d[c] = cur[c];
                pend_ts_d[c]  = ts_q;
            end
        end
        pending_d = pending_d & live;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q      <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            drop_q    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                prev_q[c]     <= '0;
                pend_val_q[c] <= '0;
                pend_ts_q[c]  <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            pending_q  <= pending_d;
            pend_val_q <= pend_val_d;
            pend_ts_q  <= pend_ts_d;
            rr_q       <= rr_d;
            drop_q     <= drop_d;
            // Tracks the bus even when disabled so re-enabling emits nothing stale.
            prev_q     <= cur;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_comb begin
        rd_valid = !empty;
        rd_ch    = head.ch;
        rd_data  = head.data;
        rd_ts    = head.ts;
        drop_cnt = drop_q;
    end

endmodule

// File: tb/tb_oreg_trace_capture.sv
// Directed self-checking bench for oreg_trace_capture (default parameters).
// Builds with TRACE_FILTER_EN also exercise the channel mask.
module tb_oreg_trace_capture;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset_n, enable, rd_ready;
    logic [15:0] bus;
    logic [3:0]  chan_mask;
    logic        rd_valid;
    logic [1:0]  rd_ch;
    logic [3:0]  rd_data;
    logic [15:0] rd_ts;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] m_ts;
    logic [15:0] exp_ts [20];
    logic [15:0] ts_hold;

    always #5 clk = ~clk;

    // Reference timestamp: value the DUT counter holds between edges.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_ts <= '0;
        else if (enable) m_ts <= m_ts + 16'd1;
    end

    oreg_trace_capture #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .TS_W   (TS_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .o_reg_bus (bus),
`ifdef TRACE_FILTER_EN
        .chan_mask (chan_mask),
`endif
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_ch     (rd_ch),
        .rd_data   (rd_data),
        .rd_ts     (rd_ts),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: wait (bounded) for a head record, check it, pop it.
    task automatic pop_check(input string tag, input int unsigned ch, input int unsigned data,
                             input int unsigned ts);
        int unsigned n = 0;
        while (!rd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_ch"}, 32'(rd_ch), ch);
        chk({tag, "_data"}, 32'(rd_data), data);
        chk({tag, "_ts"}, 32'(rd_ts), ts);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        rd_ready  = 1'b0;
        bus       = '0;
        chan_mask = 4'b1111;
        #12;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ch", 32'(rd_ch), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_ts", 32'(rd_ts), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;

        // 1: single change on ch1, latency and empty-hold behaviour
        @(negedge clk);
        bus[4 +: 4] = 4'd5;
        ts_hold = m_ts;
        @(negedge clk);
        chk("t1_not_yet", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(rd_valid), 32'd1);
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_ch", 32'(rd_ch), 32'd1);
        chk("t1_data", 32'(rd_data), 32'd5);
        chk("t1_ts", 32'(rd_ts), 32'(ts_hold));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("t1_empty", 32'(rd_valid), 32'd0);
        chk("t1_level0", 32'(level), 32'd0);
        chk("t1_hold_data", 32'(rd_data), 32'd5);
        chk("t1_hold_ch", 32'(rd_ch), 32'd1);

        // 2: simultaneous ch0/ch2 change after a fresh reset (pointer back at 0)
        reset_n = 1'b0;
        bus     = '0;
        @(negedge clk);
        reset_n = 1'b1;
        bus[0 +: 4] = 4'd3;
        bus[8 +: 4] = 4'd7;
        pop_check("t2_a", 0, 3, 0);
        pop_check("t2_b", 2, 7, 0);
        chk("t2_drop", 32'(drop_cnt), 32'd0);

        // 3: ch3 changes on 19 consecutive edges with no reader. Values 1..16 fill the
        // FIFO (last push on edge 17); 18 and 19 each overwrite a still-pending value.
        for (int unsigned i = 1; i <= 19; i++) begin
            bus[12 +: 4] = 4'(i);
            exp_ts[i] = m_ts;
            @(negedge clk);
        end
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_drop", 32'(drop_cnt), 32'd2);
        for (int unsigned i = 1; i <= 16; i++) begin
            pop_check("t3_rec", 3, i % 16, 32'(exp_ts[i]));
        end
        pop_check("t3_last", 3, 3, 32'(exp_ts[19]));
        @(negedge clk);
        chk("t3_drained", 32'(level), 32'd0);

        // 4: changes while disabled are never reported; ts holds
        enable  = 1'b0;
        ts_hold = m_ts;
        bus[4 +: 4] = 4'd9;
        @(negedge clk);
        bus[4 +: 4] = 4'd2;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t4_no_rec", 32'(rd_valid), 32'd0);
        chk("t4_level", 32'(level), 32'd0);
        bus[0 +: 4] = 4'd1;
        pop_check("t4_ts_held", 0, 1, 32'(ts_hold + 16'd3));

        // 5: timestamp wrap
        for (int unsigned n = 0; n < 70000 && m_ts != 16'hFFFE; n++) begin
            @(negedge clk);
        end
        bus[0 +: 4] = 4'd2;
        @(negedge clk);
        bus[0 +: 4] = 4'd3;
        @(negedge clk);
        bus[0 +: 4] = 4'd4;
        @(negedge clk);
        pop_check("t5_fffe", 0, 2, 32'h0000FFFE);
        pop_check("t5_ffff", 0, 3, 32'h0000FFFF);
        pop_check("t5_wrap", 0, 4, 32'h00000000);

        // 6: asynchronous reset with five records queued and drop_cnt nonzero
        bus = 16'hA865;
        repeat (5) @(negedge clk);
        bus[0 +: 4] = 4'd6;
        repeat (3) @(negedge clk);
        chk("t6_level5", 32'(level), 32'd5);
        chk("t6_drop_pre", 32'(drop_cnt), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(rd_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        chk("t6_ts", 32'(rd_ts), 32'd0);
        bus = '0;
        @(negedge clk);
        reset_n = 1'b1;

`ifdef TRACE_FILTER_EN
        chan_mask = 4'b1010;
        bus = 16'h4321;
        pop_check("flt_ch1", 1, 2, 0);
        pop_check("flt_ch3", 3, 4, 0);
        repeat (3) @(negedge clk);
        chk("flt_none", 32'(level), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
